// File: rtl/calc_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | calc_pkg : shared types and key codes for the calculator entry stage |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package calc_pkg;

  typedef enum logic [2:0] {
    ENTER_A = 3'd0,
    ENTER_B = 3'd1,
    SETUP   = 3'd2,
    DIG0    = 3'd3,
    DIG1    = 3'd4,
    DIG2    = 3'd5,
    DONE    = 3'd6
  } state_t;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } op_t;

  typedef logic [3:0] bcd_t;

  localparam logic [3:0] KEY_ADD = 4'hA;
  localparam logic [3:0] KEY_SUB = 4'hB;
  localparam logic [3:0] KEY_CLR = 4'hC;
  localparam logic [3:0] KEY_EQ  = 4'hD;

  function automatic logic is_digit(input logic [3:0] k);
    return k <= 4'd9;
  endfunction

  function automatic logic is_op(input logic [3:0] k);
    return (k == KEY_ADD) || (k == KEY_SUB);
  endfunction

  function automatic op_t key_to_op(input logic [3:0] k);
    return (k == KEY_SUB) ? OP_SUB : OP_ADD;
  endfunction

endpackage
`default_nettype wire

// File: rtl/bcd_digit_alu.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | bcd_digit_alu : one-digit BCD add/subtract with carry/borrow chain   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module bcd_digit_alu
  import calc_pkg::*;
(
  input  bcd_t i_a,
  input  bcd_t i_b,
  input  logic i_cin,
  input  op_t  i_op,
  output bcd_t o_d,
  output logic o_cout
);

  logic [4:0] w_sum;
  logic [4:0] w_sum_adj;
  logic [4:0] w_diff;
  logic [4:0] w_diff_adj;

  always_comb begin
    w_sum      = {1'b0, i_a} + {1'b0, i_b} + {4'd0, i_cin};
    w_sum_adj  = w_sum + 5'd6;
    w_diff     = {1'b0, i_a} - {1'b0, i_b} - {4'd0, i_cin};
    // A wrapped (negative) difference lands 6 above the decimal borrow result
    w_diff_adj = w_diff - 5'd6;
    o_d        = '0;
    o_cout     = 1'b0;
    if (i_op == OP_ADD) begin
      if (w_sum > 5'd9) begin
        o_d    = w_sum_adj[3:0];
        o_cout = 1'b1;
      end else begin
        o_d    = w_sum[3:0];
      end
    end else begin
      if (w_diff[4]) begin
        o_d    = w_diff_adj[3:0];
        o_cout = 1'b1;
      end else begin
        o_d    = w_diff[3:0];
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/calc_entry_fsm.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | calc_entry_fsm : operand entry, digit-serial BCD add/sub, display    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module calc_entry_fsm
  import calc_pkg::*;
#(
  parameter int DIGITS = 3
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic [3:0] keycode,
  input  logic       keystrobe,
  input  logic       bksp_strobe,
  output logic [3:0] entry_d2,
  output logic [3:0] entry_d1,
  output logic [3:0] entry_d0,
  output logic [3:0] result_d2,
  output logic [3:0] result_d1,
  output logic [3:0] result_d0,
  output logic       result_neg,
  output logic       overflow,
  output logic       display_select,
  output logic       busy
);

  localparam int W = 4 * DIGITS;

  state_t         r_state, w_state_nxt;
  op_t            r_op, w_op_nxt;
  logic [W-1:0]   r_a, w_a_nxt;
  logic [W-1:0]   r_b, w_b_nxt;
  logic [W-1:0]   r_x, w_x_nxt;
  logic [W-1:0]   r_y, w_y_nxt;
  logic [W-1:0]   r_res, w_res_nxt;
  logic [W-1:0]   r_entry, w_entry_nxt;
  logic           r_cy, w_cy_nxt;
  logic           r_neg, w_neg_nxt;
  logic           r_ovf, w_ovf_nxt;
  logic           r_sel, w_sel_nxt;
  logic           r_busy, w_busy_nxt;

  logic           w_dig, w_opk, w_eq, w_clr, w_bksp;
  bcd_t           w_alu_a, w_alu_b, w_alu_d;
  logic           w_alu_co;

  bcd_digit_alu u_alu (
    .i_a    (w_alu_a),
    .i_b    (w_alu_b),
    .i_cin  (r_cy),
    .i_op   (r_op),
    .o_d    (w_alu_d),
    .o_cout (w_alu_co)
  );

  always_comb begin
    w_alu_a = r_x[3:0];
    w_alu_b = r_y[3:0];
    case (r_state)
      DIG1: begin
        w_alu_a = r_x[7:4];
        w_alu_b = r_y[7:4];
      end
      DIG2: begin
        w_alu_a = r_x[11:8];
        w_alu_b = r_y[11:8];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_state <= ENTER_A;
      r_op    <= OP_ADD;
      r_a     <= '0;
      r_b     <= '0;
      r_x     <= '0;
      r_y     <= '0;
      r_res   <= '0;
      r_entry <= '0;
      r_cy    <= 1'b0;
      r_neg   <= 1'b0;
      r_ovf   <= 1'b0;
      r_sel   <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_op    <= w_op_nxt;
      r_a     <= w_a_nxt;
      r_b     <= w_b_nxt;
      r_x     <= w_x_nxt;
      r_y     <= w_y_nxt;
      r_res   <= w_res_nxt;
      r_entry <= w_entry_nxt;
      r_cy    <= w_cy_nxt;
      r_neg   <= w_neg_nxt;
      r_ovf   <= w_ovf_nxt;
      r_sel   <= w_sel_nxt;
      r_busy  <= w_busy_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_op_nxt    = r_op;
    w_a_nxt     = r_a;
    w_b_nxt     = r_b;
    w_x_nxt     = r_x;
    w_y_nxt     = r_y;
    w_res_nxt   = r_res;
    w_entry_nxt = r_entry;
    w_cy_nxt    = r_cy;
    w_neg_nxt   = r_neg;
    w_ovf_nxt   = r_ovf;
    w_sel_nxt   = r_sel;
    w_busy_nxt  = r_busy;
    w_dig       = keystrobe && is_digit(keycode);
    w_opk       = keystrobe && is_op(keycode);
    w_eq        = keystrobe && (keycode == KEY_EQ);
    w_clr       = keystrobe && (keycode == KEY_CLR);
    // A key on the same edge wins over backspace
    w_bksp      = bksp_strobe && !keystrobe;

    if (w_clr) begin
      w_state_nxt = ENTER_A;
      w_op_nxt    = OP_ADD;
      w_a_nxt     = '0;
      w_b_nxt     = '0;
      w_x_nxt     = '0;
      w_y_nxt     = '0;
      w_res_nxt   = '0;
      w_cy_nxt    = 1'b0;
      w_neg_nxt   = 1'b0;
      w_ovf_nxt   = 1'b0;
      w_sel_nxt   = 1'b0;
      w_busy_nxt  = 1'b0;
    end else begin
      case (r_state)
        ENTER_A: begin
          if (w_dig) begin
            if (r_a[W-1 -: 4] == 4'd0) w_a_nxt = {r_a[W-5:0], keycode};
          end else if (w_opk) begin
            w_op_nxt    = key_to_op(keycode);
            w_b_nxt     = '0;
            w_state_nxt = ENTER_B;
          end else if (w_bksp) begin
            w_a_nxt = {4'd0, r_a[W-1:4]};
          end
        end
        ENTER_B: begin
          if (w_dig) begin
            if (r_b[W-1 -: 4] == 4'd0) w_b_nxt = {r_b[W-5:0], keycode};
          end else if (w_opk) begin
            w_op_nxt = key_to_op(keycode);
          end else if (w_eq) begin
            w_busy_nxt  = 1'b1;
            w_state_nxt = SETUP;
          end else if (w_bksp) begin
            w_b_nxt = {4'd0, r_b[W-1:4]};
          end
        end
        SETUP: begin
          // Packed BCD orders the same as its raw binary value
          w_neg_nxt = (r_op == OP_SUB) && (r_a < r_b);
          w_x_nxt   = w_neg_nxt ? r_b : r_a;
          w_y_nxt   = w_neg_nxt ? r_a : r_b;
          w_cy_nxt  = 1'b0;
          w_ovf_nxt = 1'b0;
          w_state_nxt = DIG0;
        end
        DIG0: begin
          w_res_nxt[3:0] = w_alu_d;
          w_cy_nxt       = w_alu_co;
          w_state_nxt    = DIG1;
        end
        DIG1: begin
          w_res_nxt[7:4] = w_alu_d;
          w_cy_nxt       = w_alu_co;
          w_state_nxt    = DIG2;
        end
        DIG2: begin
          w_res_nxt[11:8] = w_alu_d;
          w_cy_nxt        = w_alu_co;
          if (r_op == OP_ADD) w_ovf_nxt = w_alu_co;
          w_busy_nxt  = 1'b0;
          w_sel_nxt   = 1'b1;
          w_state_nxt = DONE;
        end
        DONE: begin
          if (w_dig) begin
            w_a_nxt     = {{(W-4){1'b0}}, keycode};
            w_res_nxt   = '0;
            w_neg_nxt   = 1'b0;
            w_ovf_nxt   = 1'b0;
            w_sel_nxt   = 1'b0;
            w_state_nxt = ENTER_A;
          end else if (w_opk && !r_neg && !r_ovf) begin
            w_a_nxt     = r_res;
            w_op_nxt    = key_to_op(keycode);
            w_b_nxt     = '0;
            w_sel_nxt   = 1'b0;
            w_state_nxt = ENTER_B;
          end
        end
        default: w_state_nxt = ENTER_A;
      endcase
    end

    if (w_state_nxt == ENTER_A)      w_entry_nxt = w_a_nxt;
    else if (w_state_nxt == ENTER_B) w_entry_nxt = w_b_nxt;
  end

  assign entry_d2       = r_entry[11:8];
  assign entry_d1       = r_entry[7:4];
  assign entry_d0       = r_entry[3:0];
  assign result_d2      = r_res[11:8];
  assign result_d1      = r_res[7:4];
  assign result_d0      = r_res[3:0];
  assign result_neg     = r_neg;
  assign overflow       = r_ovf;
  assign display_select = r_sel;
  assign busy           = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_calc_entry_fsm.sv
`default_nettype none
// Self-checking bench: decimal reference model compared every cycle, plus directed literal checks.
module tb_calc_entry_fsm;

  logic       clock;
  logic       resetn;
  logic [3:0] keycode;
  logic       keystrobe;
  logic       bksp_strobe;
  logic [3:0] entry_d2, entry_d1, entry_d0;
  logic [3:0] result_d2, result_d1, result_d0;
  logic       result_neg, overflow, display_select, busy;

  int errors = 0;
  int checks = 0;

  calc_entry_fsm #(.DIGITS(3)) dut (
    .clock          (clock),
    .resetn         (resetn),
    .keycode        (keycode),
    .keystrobe      (keystrobe),
    .bksp_strobe    (bksp_strobe),
    .entry_d2       (entry_d2),
    .entry_d1       (entry_d1),
    .entry_d0       (entry_d0),
    .result_d2      (result_d2),
    .result_d1      (result_d1),
    .result_d0      (result_d0),
    .result_neg     (result_neg),
    .overflow       (overflow),
    .display_select (display_select),
    .busy           (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // phase: 0 entering A, 1 entering B, 2 computing, 3 showing result
  typedef struct {
    int a, b, res, entry, cnt, phase;
    bit sub, neg, ovf, sel, busy;
  } model_t;

  model_t m;

  function automatic model_t model_step(input model_t s, input logic ks,
                                        input logic [3:0] kc, input logic bk);
    model_t n = s;
    int     k = int'(kc);
    if (ks && kc == 4'hC) begin
      n = '{default: 0};
      return n;
    end
    case (s.phase)
      0, 1: begin
        if (ks) begin
          if (k <= 9) begin
            if (s.phase == 0 && s.a < 100) n.a = s.a * 10 + k;
            if (s.phase == 1 && s.b < 100) n.b = s.b * 10 + k;
          end else if (kc == 4'hA || kc == 4'hB) begin
            n.sub = (kc == 4'hB);
            if (s.phase == 0) begin
              n.b     = 0;
              n.phase = 1;
            end
          end else if (kc == 4'hD && s.phase == 1) begin
            n.phase = 2;
            n.cnt   = 4;
            n.busy  = 1;
          end
        end else if (bk) begin
          if (s.phase == 0) n.a = s.a / 10;
          else              n.b = s.b / 10;
        end
      end
      2: begin
        n.cnt = s.cnt - 1;
        if (n.cnt == 0) begin
          if (!s.sub) begin
            n.ovf = (s.a + s.b) > 999;
            n.res = (s.a + s.b) % 1000;
            n.neg = 0;
          end else begin
            n.neg = s.a < s.b;
            n.res = (s.a < s.b) ? s.b - s.a : s.a - s.b;
            n.ovf = 0;
          end
          n.busy  = 0;
          n.sel   = 1;
          n.phase = 3;
        end
      end
      default: begin
        if (ks && k <= 9) begin
          n.a = k; n.res = 0; n.neg = 0; n.ovf = 0; n.sel = 0; n.phase = 0;
        end else if (ks && (kc == 4'hA || kc == 4'hB) && !s.neg && !s.ovf) begin
          n.a = s.res; n.sub = (kc == 4'hB); n.b = 0; n.sel = 0; n.phase = 1;
        end
      end
    endcase
    if (n.phase == 0)      n.entry = n.a;
    else if (n.phase == 1) n.entry = n.b;
    return n;
  endfunction

  always @(posedge clock or negedge resetn) begin
    if (!resetn) m <= '{default: 0};
    else         m <= model_step(m, keystrobe, keycode, bksp_strobe);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] ent_val();
    return {28'd0, entry_d2} * 32'd100 + {28'd0, entry_d1} * 32'd10 + {28'd0, entry_d0};
  endfunction

  function automatic logic [31:0] res_val();
    return {28'd0, result_d2} * 32'd100 + {28'd0, result_d1} * 32'd10 + {28'd0, result_d0};
  endfunction

  always @(negedge clock) begin
    chk("busy", {31'd0, busy}, {31'd0, m.busy});
    chk("select", {31'd0, display_select}, {31'd0, m.sel});
    chk("entry", ent_val(), m.entry);
    if (!m.busy) begin
      chk("result", res_val(), m.res);
      chk("neg", {31'd0, result_neg}, {31'd0, m.neg});
      chk("ovf", {31'd0, overflow}, {31'd0, m.ovf});
    end
  end

  task automatic press(input logic [3:0] kc, input logic bk);
    @(negedge clock);
    keycode     = kc;
    keystrobe   = (kc != 4'hF) || !bk;
    bksp_strobe = bk;
    @(posedge clock);
    #1;
    keystrobe   = 1'b0;
    bksp_strobe = 1'b0;
  endtask

  task automatic key(input logic [3:0] kc);
    press(kc, 1'b0);
  endtask

  task automatic bksp();
    press(4'hF, 1'b1);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic keys3(input int v);
    key(4'(v / 100));
    key(4'((v / 10) % 10));
    key(4'(v % 10));
  endtask

  initial begin
    resetn      = 1'b0;
    keycode     = 4'h0;
    keystrobe   = 1'b0;
    bksp_strobe = 1'b0;
    idle(3);
    chk("rst_entry", ent_val(), 0);
    chk("rst_busy", {31'd0, busy}, 0);
    #3 resetn = 1'b1;

    key(4'h1); key(4'h2); key(4'h3);
    chk("entry_123", ent_val(), 123);
    key(4'h4);
    chk("entry_full", ent_val(), 123);
    bksp();
    chk("entry_bksp", ent_val(), 12);

    key(4'hC);
    keys3(123); key(4'hA); keys3(456); key(4'hD);
    chk("busy_e0", {31'd0, busy}, 1);
    idle(3);
    chk("busy_e3", {31'd0, busy}, 1);
    idle(1);
    chk("add_res", res_val(), 579);
    chk("add_sel", {31'd0, display_select}, 1);
    chk("add_busy", {31'd0, busy}, 0);
    chk("add_ovf", {31'd0, overflow}, 0);

    key(4'hC);
    keys3(999); key(4'hA); keys3(2); key(4'hD);
    idle(4);
    chk("ovf_res", res_val(), 1);
    chk("ovf_flag", {31'd0, overflow}, 1);
    key(4'hA);
    chk("ovf_opkey_sel", {31'd0, display_select}, 1);

    key(4'hC);
    keys3(45); key(4'hB); keys3(100); key(4'hD);
    idle(4);
    chk("sub_res", res_val(), 55);
    chk("sub_neg", {31'd0, result_neg}, 1);
    key(4'h7);
    chk("new_entry", ent_val(), 7);
    chk("new_neg", {31'd0, result_neg}, 0);
    chk("new_sel", {31'd0, display_select}, 0);

    key(4'hC);
    keys3(300); key(4'hB); keys3(50); key(4'hD);
    idle(4);
    chk("chain1_res", res_val(), 250);
    key(4'hA); key(4'h1); key(4'h0); key(4'hD);
    idle(4);
    chk("chain2_res", res_val(), 260);
    chk("chain2_neg", {31'd0, result_neg}, 0);

    key(4'hC);
    key(4'h1); key(4'hA); key(4'h2); key(4'hD);
    idle(2);
    key(4'hC);
    chk("clr_busy", {31'd0, busy}, 0);
    chk("clr_res", res_val(), 0);
    chk("clr_entry", ent_val(), 0);

    key(4'h1); key(4'hA); key(4'h2); key(4'hD);
    idle(2);
    #2 resetn = 1'b0;
    #1;
    chk("rstmid_busy", {31'd0, busy}, 0);
    chk("rstmid_res", res_val(), 0);
    chk("rstmid_sel", {31'd0, display_select}, 0);
    #2 resetn = 1'b1;

    for (int i = 0; i < 3000; i++) begin
      int r;
      @(negedge clock);
      r           = int'($urandom_range(0, 99));
      keystrobe   = 1'b1;
      bksp_strobe = ($urandom_range(0, 6) == 0);
      if (r < 45)      keycode = 4'($urandom_range(0, 9));
      else if (r < 55) keycode = ($urandom_range(0, 1) == 0) ? 4'hA : 4'hB;
      else if (r < 61) keycode = 4'hD;
      else if (r < 62) keycode = 4'hC;
      else if (r < 64) keycode = ($urandom_range(0, 1) == 0) ? 4'hE : 4'hF;
      else begin
        keystrobe = 1'b0;
        keycode   = 4'($urandom_range(0, 15));
      end
      if (i == 1500) begin
        #2 resetn = 1'b0;
        #4 resetn = 1'b1;
      end
    end
    @(negedge clock);
    keystrobe   = 1'b0;
    bksp_strobe = 1'b0;
    idle(6);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
